// File: rtl/nios_wallet_pio_pkg.sv
// rtl/nios_wallet_pio_pkg.sv - shared constants for the wallet push-button input port
//
// Purpose: register addresses, edge-type encodings and the per-bit edge
// qualifier used by nios_wallet_pi_button.
package nios_wallet_pio_pkg;

  // Avalon word addresses; address 1 is reserved and reads as zero.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Values accepted by the EDGE_TYPE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when the transition prev -> cur is one the port is configured to capture.
  function automatic logic edge_hit(input int edge_type, input logic prev, input logic cur);
    case (edge_type)
      EDGE_RISE: return ~prev & cur;
      EDGE_FALL: return prev & ~cur;
      default:   return prev ^ cur;
    endcase
  endfunction

endpackage

// File: rtl/nios_wallet_debounce.sv
// rtl/nios_wallet_debounce.sv - one-bit synchronizer and debouncer
//
// Purpose: brings one raw asynchronous input into the clk domain through a
// two-flop synchronizer, then only accepts a new level once the synchronized
// value has disagreed with the accepted level for DEBOUNCE_CYCLES
// consecutive cycles.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   din      - raw asynchronous input
//   stable   - debounced level (IDLE_LEVEL out of reset)
module nios_wallet_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // The counter tracks how many consecutive cycles the synchronized value
  // has differed from the accepted level. Any agreeing cycle restarts it, and
  // it clears on acceptance, so it never runs past CNT_LAST and cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/nios_wallet_pi_button.sv
// rtl/nios_wallet_pi_button.sv - Avalon-MM push-button input port with edge capture and irq
//
// Purpose: samples WIDTH external buttons/switches, debounces each bit,
// latches configured edges into EDGECAP and raises a maskable level irq.
//
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   address, chipselect,  - Avalon-MM slave: word address, select,
//   write_n, writedata      active-low write strobe, write data
//   in_port               - raw asynchronous button inputs
//   readdata              - registered read data (latency 1, no read strobe)
//   irq                   - active-high level interrupt
//
// Register map: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (R/W1C).
module nios_wallet_pi_button
  import nios_wallet_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_wallet_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr_en = chipselect && !write_n;

  // Upper write-data bits have no storage when WIDTH < 32.
  assign unused_wdata = &{1'b0, writedata};

  // prev_q resets to the idle level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= {WIDTH{IDLE_LEVEL}};
    end else begin
      prev_q <= stable;
    end
  end

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_det[i] = edge_hit(EDGE_TYPE, prev_q[i], stable[i]);
    end
  end

  always_comb begin
    cap_clr = '0;
    if (wr_en && address == ADDR_EDGECAP) begin
      cap_clr = writedata[WIDTH-1:0];
    end
  end

  // A new edge is ORed in after the clear so it survives a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap_q <= '0;
    end else begin
      edge_cap_q <= (edge_cap_q & ~cap_clr) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
    end else if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask_q <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap_q;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios_wallet_pi_button.sv
// tb/tb_nios_wallet_pi_button.sv - self-checking bench for nios_wallet_pi_button
module tb_nios_wallet_pi_button;

  localparam int W = 4;
  localparam int D = 4;
  localparam int H = D + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [W-1:0] m_stable, m_prev, m_cap, m_mask;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [0:H-1];   // hist[0] = raw sample taken at the latest edge

  nios_wallet_pi_button #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1'b1), .EDGE_TYPE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < H; i++) hist[i] = '1;
    m_stable = '1; m_prev = '1; m_cap = '0; m_mask = '0; m_rd = '0;
  endtask

  // A level is accepted once the synchronized input (raw delayed two samples)
  // has shown the opposite level for D consecutive cycles; a falling accepted
  // level is captured one cycle later.
  task automatic model_step(input logic [W-1:0] raw, input logic cs, input logic wr,
                            input logic [1:0] a, input logic [31:0] d);
    logic [W-1:0] st_n, fall, clr;
    logic all_diff;
    case (a)
      2'd0: m_rd = {28'b0, m_stable};
      2'd2: m_rd = {28'b0, m_mask};
      2'd3: m_rd = {28'b0, m_cap};
      default: m_rd = '0;
    endcase
    fall = m_prev & ~m_stable;
    clr  = (cs && wr && a == 2'd3) ? d[W-1:0] : '0;
    for (int i = H-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = raw;
    st_n = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j < H; j++) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) st_n[b] = ~m_stable[b];
    end
    m_prev = m_stable;
    m_stable = st_n;
    m_cap = (m_cap & ~clr) | fall;
    if (cs && wr && a == 2'd2) m_mask = d[W-1:0];
  endtask

  task automatic step(input logic cs, input logic wr, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs; write_n = ~wr; address = a; writedata = d;
    @(posedge clk);
    model_step(in_port, cs, wr, a, d);
    #1;
    chk("readdata", readdata, m_rd);
    chk("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    @(negedge clk);
  endtask

  task automatic do_reset();
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int hold;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1. reset state
    step(0, 0, 2'd0, 0);
    chk("rst_data", readdata, 32'hF);
    step(0, 0, 2'd3, 0);
    chk("rst_cap", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // 2. press bit0: stable after 2+4 edges, visible on readdata one edge later
    in_port = 4'hE;
    repeat (5) step(0, 0, 2'd0, 0);
    step(0, 0, 2'd0, 0);
    chk("press_edge6", readdata, 32'hF);
    step(0, 0, 2'd0, 0);
    chk("press_edge7", readdata, 32'hE);
    step(0, 0, 2'd3, 0);
    chk("press_cap", readdata, 32'h1);
    chk("press_irq_masked", {31'b0, irq}, 32'h0);

    // 3. release bit0, then 3-cycle glitch on bit1
    in_port = 4'hF;
    repeat (8) step(0, 0, 2'd0, 0);
    in_port = 4'hD;
    repeat (3) step(0, 0, 2'd0, 0);
    in_port = 4'hF;
    repeat (8) step(0, 0, 2'd0, 0);
    chk("glitch_data", readdata, 32'hF);
    step(0, 0, 2'd3, 0);
    chk("glitch_cap", readdata, 32'h1);

    // 4. unmask then W1C
    step(1, 1, 2'd2, 32'h1);
    chk("unmask_irq", {31'b0, irq}, 32'h1);
    step(1, 1, 2'd3, 32'h1);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    step(0, 0, 2'd3, 0);
    chk("w1c_cap", readdata, 32'h0);

    // 5. edge on bit2 in the same cycle as its W1C
    in_port = 4'hB;
    repeat (6) step(0, 0, 2'd0, 0);
    step(1, 1, 2'd3, 32'h4);
    step(0, 0, 2'd3, 0);
    chk("simul_cap", readdata & 32'h4, 32'h4);

    // 6. reset two cycles into a press
    in_port = 4'hF;
    repeat (8) step(0, 0, 2'd0, 0);
    in_port = 4'hE;
    repeat (2) step(0, 0, 2'd0, 0);
    do_reset();
    step(0, 0, 2'd3, 0);
    chk("mid_rst_cap", readdata, 32'h0);
    repeat (4) step(0, 0, 2'd0, 0);
    step(0, 0, 2'd0, 0);
    chk("mid_rst_edge6", readdata, 32'hF);
    step(0, 0, 2'd0, 0);
    chk("mid_rst_edge7", readdata, 32'hE);

    // Randomized traffic against the model
    hold = 0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           2'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
